// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder
//
// Activation feeder for the weight-stationary systolic array. Incoming activation vectors are
// buffered in a small FIFO. A start (weights loaded) in IDLE streams exactly MATRIX_SIZE vectors
// into the array row inputs, skewed so that row i sees element i delayed by i cycles. Afterwards
// the skew pipeline drains and a one-cycle done pulse is raised.
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous, active-high reset
//   general_enable - global enable; low freezes FSM, counters, pops and skew registers
//   start          - weights loaded; only acted on in IDLE
//   in_valid       - upstream vector valid
//   in_ready       - FIFO not full (combinational)
//   in_data        - input vector, element i at [i*DATA_SIZE +: DATA_SIZE]
//   row_data       - registered skewed element per row, same packing as in_data
//   row_valid      - per-row valid for row_data
//   busy           - high in STREAM, DRAIN and DONE
//   done           - high for the DONE cycle

module systolic_input_feeder #(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             general_enable,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] in_data,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] row_data,
  output logic [MATRIX_SIZE-1:0]           row_valid,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned VecW  = MATRIX_SIZE * DATA_SIZE;
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned CntW  = $clog2(MATRIX_SIZE + 1);
  localparam logic [CntW-1:0] MatCnt = CntW'(MATRIX_SIZE);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] pop_count_q, pop_count_d;
  logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [VecW-1:0] mem_q [FIFO_DEPTH];

  logic            full, empty, push, pop;
  logic [VecW-1:0] pop_data;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign full     = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                    (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign in_ready = ~full;
  // Pushes ignore general_enable so upstream can keep filling during a freeze.
  assign push     = in_valid && !full;
  assign pop      = (state_q == StStream) && general_enable && !empty && (pop_count_q < MatCnt);
  assign pop_data = mem_q[rd_ptr_q[AddrW-1:0]];

  assign wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, pop};

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= in_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    pop_count_d = pop_count_q;
    drain_cnt_d = drain_cnt_q;
    if (general_enable) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d     = StStream;
            pop_count_d = '0;
          end
        end
        StStream: begin
          if (pop) begin
            pop_count_d = pop_count_q + OneCnt;
            if (pop_count_q == MatCnt - OneCnt) begin
              state_d     = StDrain;
              drain_cnt_d = MatCnt;
            end
          end
        end
        StDrain: begin
          drain_cnt_d = drain_cnt_q - OneCnt;
          if (drain_cnt_q == OneCnt) begin
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pop_count_q <= '0;
      drain_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pop_count_q <= pop_count_d;
      drain_cnt_q <= drain_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Row i carries {valid, data} through i+1 registers: an i-deep skew chain plus the output
  // register. Non-pop cycles inject a zero bubble so stalls keep the same skew on every row.
  for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_row
    logic [DATA_SIZE:0]   sk_q [i+1];
    logic [DATA_SIZE:0]   sk_d [i+1];
    logic [DATA_SIZE-1:0] elem;

    always_comb begin
      elem     = pop ? pop_data[i*DATA_SIZE +: DATA_SIZE] : '0;
      sk_d[0]  = {pop, elem};
      for (int k = 1; k <= i; k++) begin
        sk_d[k] = sk_q[k-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) begin
          sk_q[k] <= '0;
        end
      end else if (general_enable) begin
        for (int k = 0; k <= i; k++) begin
          sk_q[k] <= sk_d[k];
        end
      end
    end

    assign row_valid[i]                         = sk_q[i][DATA_SIZE];
    assign row_data[i*DATA_SIZE +: DATA_SIZE] = sk_q[i][DATA_SIZE-1:0];
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Self-checking bench for systolic_input_feeder. A transaction-level model (vector queue plus a
// history of injected row-0 entries) predicts every output each cycle; directed scenarios add
// latency checks against fixed cycle counts.

module tb_systolic_input_feeder;

  localparam int N     = 2;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int VW    = N * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          general_enable;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic [VW-1:0] row_data;
  logic [N-1:0]  row_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  systolic_input_feeder #(
    .MATRIX_SIZE(N),
    .DATA_SIZE  (W),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .general_enable(general_enable),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .row_data      (row_data),
    .row_valid     (row_valid),
    .busy          (busy),
    .done          (done)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_ready;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue; m_hist[i] is the {valid, vector} injected i enabled
  // cycles ago, which is what row i shows now.
  logic [VW-1:0] m_q[$];
  logic [VW:0]   m_hist [N];
  bit            m_session;
  bit            m_done;
  int            m_pops_left;
  int            m_tail;

  function automatic void model_reset();
    m_q.delete();
    for (int i = 0; i < N; i++) m_hist[i] = '0;
    m_session   = 1'b0;
    m_done      = 1'b0;
    m_pops_left = 0;
    m_tail      = 0;
  endfunction

  function automatic void model_edge(input bit e, input bit s, input bit v, input logic [VW-1:0] d);
    bit          do_push;
    logic [VW:0] entry;
    do_push = v && (m_q.size() < DEPTH);
    entry   = '0;
    if (e) begin
      if (m_done) begin
        m_done    = 1'b0;
        m_session = 1'b0;
      end else if (m_pops_left > 0) begin
        if (m_q.size() > 0) begin
          entry = {1'b1, m_q.pop_front()};
          m_pops_left--;
          if (m_pops_left == 0) m_tail = N;
        end
      end else if (m_tail > 0) begin
        m_tail--;
        if (m_tail == 0) m_done = 1'b1;
      end else if (!m_session && s) begin
        m_session   = 1'b1;
        m_pops_left = N;
      end
      for (int i = N - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = entry;
    end
    if (do_push) m_q.push_back(d);
  endfunction

  task automatic check_outputs();
    logic [VW-1:0] exp_d;
    logic [N-1:0]  exp_v;
    for (int i = 0; i < N; i++) begin
      exp_v[i]         = m_hist[i][VW];
      exp_d[i*W +: W]  = m_hist[i][VW] ? m_hist[i][i*W +: W] : '0;
    end
    check_val("row_data", row_data, exp_d);
    check_val("row_valid", row_valid, exp_v);
    check_val("busy", busy, m_session);
    check_val("done", done, m_done);
  endtask

  // Called just after a falling edge: drive, check in_ready, clock, check outputs.
  task automatic cycle(input bit e, input bit s, input bit v, input logic [VW-1:0] d);
    general_enable = e;
    start          = s;
    in_valid       = v;
    in_data        = d;
    #1;
    last_ready = in_ready;
    check_val("in_ready", in_ready, m_q.size() < DEPTH);
    @(posedge clk);
    model_edge(e, s, v, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_async();
    #2;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_val("rst_row_data", row_data, 0);
    check_val("rst_row_valid", row_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_in_ready", in_ready, 1);
    model_reset();
    #1;
    reset = 1'b0;
    @(posedge clk);
    model_edge(general_enable, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_done(input int limit, output int k);
    k = 0;
    while (!done && k < limit) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      k++;
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input int a, input int b);
    return {W'(b), W'(a)};
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    return {$urandom, $urandom};
  endfunction

  int k;
  int acc;

  initial begin
    reset          = 1'b1;
    general_enable = 1'b1;
    start          = 1'b0;
    in_valid       = 1'b0;
    in_data        = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_val("reset_row_data", row_data, 0);
    check_val("reset_row_valid", row_valid, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_in_ready", in_ready, 1);
    reset = 1'b0;

    // Skew with A={1,2}, B={3,4}.
    cycle(1'b1, 1'b0, 1'b1, mkvec(1, 2));
    cycle(1'b1, 1'b0, 1'b1, mkvec(3, 4));
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_val("skew_c2_row0", row_data[W-1:0], 1);
    check_val("skew_c2_valid", row_valid, 2'b01);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_val("skew_c3_rows", row_data, mkvec(3, 2));
    check_val("skew_c3_valid", row_valid, 2'b11);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_val("skew_c4_row1", row_data[2*W-1:W], 4);
    check_val("skew_c4_valid", row_valid, 2'b10);
    wait_done(20, k);
    check_val("skew_latency", 4 + k, 5);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Empty-FIFO bubble: B arrives three cycles after start.
    cycle(1'b1, 1'b0, 1'b1, mkvec(5, 6));
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b1, mkvec(7, 8));
    wait_done(20, k);
    check_val("bubble_done", done, 1);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Enable freeze for 3 cycles mid-STREAM, with a push during the freeze.
    cycle(1'b1, 1'b0, 1'b1, mkvec(9, 10));
    cycle(1'b1, 1'b0, 1'b1, mkvec(11, 12));
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b1, mkvec(13, 14));
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    wait_done(20, k);
    check_val("freeze_latency", 5 + k, 8);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Backpressure: hold in_valid with no start.
    reset_async();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 1'b1, mkvec(20 + i, 40 + i));
      acc += int'(last_ready);
    end
    check_val("bp_accepted", acc, 4);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check_val("bp_ready_after_pop", in_ready, 1);
    wait_done(20, k);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    wait_done(20, k);
    check_val("bp_second_done", done, 1);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Reset mid-DRAIN with vectors still buffered.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, rnd_vec());
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    reset_async();
    cycle(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, '0);
      check_val("post_rst_bubble", row_valid, 0);
    end
    cycle(1'b1, 1'b0, 1'b1, rnd_vec());
    cycle(1'b1, 1'b0, 1'b1, rnd_vec());
    wait_done(20, k);
    check_val("post_rst_done", done, 1);
    cycle(1'b1, 1'b0, 1'b0, '0);

    // Pointer wrap: three back-to-back matrices.
    for (int m = 0; m < 3; m++) begin
      cycle(1'b1, 1'b0, 1'b1, rnd_vec());
      cycle(1'b1, 1'b0, 1'b1, rnd_vec());
      cycle(1'b1, 1'b1, 1'b0, '0);
      wait_done(20, k);
      check_val("wrap_done", done, 1);
      cycle(1'b1, 1'b0, 1'b0, '0);
    end

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_async();
      end else begin
        cycle($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 2) != 0, rnd_vec());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
